read_fifo_pixel_unpacker: RTL and testbench

//  Downstream neighbour of the HDMI Avalon read master.
//  - Buffers 32-bit readdata words returned on the bus into a synchronous FIFO.
//  - Drives the almost-full flag that throttles the read master's request issue.
//  - Presents the buffered words as a pixel stream with valid/ready handshake and SOF/EOL framing for the HDMI output stage.

---
 rtl/vlc_hdmi_pkg.sv | 26 ++
 rtl/sync_fifo_ram.sv | 38 +++
 rtl/read_fifo_pixel_unpacker.sv | 210 +++++++++++++++++++++
 tb/tb_read_fifo_pixel_unpacker.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_hdmi_pkg.sv
// ---------------------------------------------------------------------------
// vlc_hdmi_pkg
//   Shared widths and defaults for the HDMI read path: bus word width, RGB
//   pixel width, pixel FIFO sizing and default active-video geometry.
//   Also provides the helper that extracts the {R,G,B} pixel from a bus word.
// ---------------------------------------------------------------------------
package vlc_hdmi_pkg;

  localparam int RGB_W          = 24;
  localparam int WORD_W         = 32;

  localparam int FIFO_DEPTH     = 64;
  localparam int FIFO_AF_MARGIN = 4;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int V_ACTIVE_DEF   = 480;

  typedef logic [RGB_W-1:0]  rgb_t;
  typedef logic [WORD_W-1:0] busWord_t;

  // Pixel sits in the low three bytes as {R,G,B}; the top byte is padding.
  function automatic rgb_t wordToRgb(input busWord_t word);
    return word[RGB_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// ---------------------------------------------------------------------------
// sync_fifo_ram
//   Simple dual-port RAM for the pixel FIFO: one write port, one read port,
//   both on iClk. The read is registered (one clock of latency). A read and a
//   write to the same address on the same edge return the OLD contents; the
//   parent tracks that case itself. The array has no reset.
//
// Ports
//   iClk     in   1        clock
//   iWrEn    in   1        write strobe
//   iWrAddr  in   ADDR_W   write address
//   iWrData  in   DATA_W   write data
//   iRdAddr  in   ADDR_W   read address, sampled every edge
//   oRdData  out  DATA_W   registered read data
// ---------------------------------------------------------------------------
module sync_fifo_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              iClk,
  input  logic              iWrEn,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [DATA_W-1:0] oRdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge iClk) begin
    if (iWrEn) begin
      mem[iWrAddr] <= iWrData;
    end
    oRdData <= mem[iRdAddr];
  end

endmodule

// File: rtl/read_fifo_pixel_unpacker.sv
// ---------------------------------------------------------------------------
// read_fifo_pixel_unpacker
//   Sits behind the HDMI Avalon read master. Buffers returned readdata words
//   in a RAM FIFO, throttles the master with an almost-full flag, and hands
//   the words on as a valid/ready pixel stream with SOF/EOL framing.
//
//   The RAM read port always reads the entry at the next read pointer, so the
//   RAM output register carries the FIFO head. A prefetch copies that head
//   into the output register (oPixel) and advances the read pointer. The only
//   time the head register is not yet trustworthy is the cycle after a write
//   landed on the very address being read (read-during-write returns old
//   data); headStale blocks the prefetch for that one cycle. This gives a
//   two-edge latency from an empty FIFO and one pixel per cycle when popping
//   back to back, with only the output register holding data outside the RAM.
//
// Ports
//   iClk             in   1         system clock
//   iReset_n         in   1         async active-low reset
//   iClear           in   1         sync flush of FIFO, counters and overflow
//   iRd_data         in   32        Avalon readdata, pixel in [23:0]
//   iRd_Data_valid   in   1         Avalon readdatavalid
//   oFF_almost_full  out  1         oUsedw >= DEPTH-AF_MARGIN (registered)
//   oFF_full         out  1         oUsedw == DEPTH
//   oFF_empty        out  1         oUsedw == 0
//   oUsedw           out  ADDR_W+1  words held in RAM
//   oOverflow        out  1         sticky: a word was dropped while full
//   oPixel           out  24        pixel data
//   oPixel_valid     out  1         output register holds a pixel
//   iPixel_ready     in   1         consumer accepts the pixel
//   oSOF             out  1         first pixel of frame
//   oEOL             out  1         last pixel of line
// ---------------------------------------------------------------------------
module read_fifo_pixel_unpacker
  import vlc_hdmi_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int AF_MARGIN = FIFO_AF_MARGIN,
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iClear,
  input  logic [WORD_W-1:0] iRd_data,
  input  logic              iRd_Data_valid,
  output logic              oFF_almost_full,
  output logic              oFF_full,
  output logic              oFF_empty,
  output logic [ADDR_W:0]   oUsedw,
  output logic              oOverflow,
  output logic [RGB_W-1:0]  oPixel,
  output logic              oPixel_valid,
  input  logic              iPixel_ready,
  output logic              oSOF,
  output logic              oEOL
);

  localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [ADDR_W:0] USED_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] USED_AF   = (ADDR_W+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W:0] USED_ONE  = (ADDR_W+1)'(1);
  localparam logic [X_W-1:0]  X_LAST    = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]  Y_LAST    = Y_W'(V_ACTIVE - 1);

  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W-1:0] rdPtrNext;
  logic [ADDR_W:0]   usedw;
  logic [ADDR_W:0]   usedwNext;
  logic              headStale;
  logic              almostFull;
  logic              overflow;
  logic              pixValid;
  rgb_t              pixel;
  rgb_t              ramQ;
  logic [X_W-1:0]    xCnt;
  logic [Y_W-1:0]    yCnt;

  logic              full;
  logic              empty;
  logic              wrAccept;
  logic              pop;
  logic              prefetch;

  // Top byte of the bus word carries no pixel information.
  logic [WORD_W-RGB_W-1:0] unusedPad;
  assign unusedPad = iRd_data[WORD_W-1:RGB_W];

  // Full is taken from the registered count, i.e. before this edge's prefetch.
  assign full     = (usedw == USED_FULL);
  assign empty    = (usedw == '0);
  assign wrAccept = iRd_Data_valid && !full && !iClear;
  assign pop      = pixValid && iPixel_ready;
  assign prefetch = !iClear && !empty && !headStale && (!pixValid || pop);

  always_comb begin
    rdPtrNext = rdPtr;
    if (iClear) begin
      rdPtrNext = '0;
    end else if (prefetch) begin
      rdPtrNext = rdPtr + ADDR_W'(1);
    end
  end

  always_comb begin
    usedwNext = usedw;
    if (iClear) begin
      usedwNext = '0;
    end else if (wrAccept && !prefetch) begin
      usedwNext = usedw + USED_ONE;
    end else if (!wrAccept && prefetch) begin
      usedwNext = usedw - USED_ONE;
    end
  end

  sync_fifo_ram #(
    .DATA_W (RGB_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .iClk    (iClk),
    .iWrEn   (wrAccept),
    .iWrAddr (wrPtr),
    .iWrData (wordToRgb(iRd_data)),
    .iRdAddr (rdPtrNext),
    .oRdData (ramQ)
  );

  // Pointers, count and flags.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      usedw      <= '0;
      headStale  <= 1'b0;
      almostFull <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rdPtr      <= rdPtrNext;
      usedw      <= usedwNext;
      almostFull <= (usedwNext >= USED_AF);
      // The RAM reads rdPtrNext on this same edge; if the write hits that
      // address, the head register captures the old contents.
      headStale  <= wrAccept && (wrPtr == rdPtrNext);
      if (iClear) begin
        wrPtr    <= '0;
        overflow <= 1'b0;
      end else begin
        if (wrAccept) begin
          wrPtr <= wrPtr + ADDR_W'(1);
        end
        if (iRd_Data_valid && full) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Output register: refilled from the RAM head on prefetch, emptied on pop.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      pixValid <= 1'b0;
      pixel    <= '0;
    end else if (iClear) begin
      pixValid <= 1'b0;
      pixel    <= '0;
    end else if (prefetch) begin
      pixValid <= 1'b1;
      pixel    <= ramQ;
    end else if (pop) begin
      pixValid <= 1'b0;
    end
  end

  // Raster position of the pixel currently in the output register.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      xCnt <= '0;
      yCnt <= '0;
    end else if (iClear) begin
      xCnt <= '0;
      yCnt <= '0;
    end else if (pop) begin
      if (xCnt == X_LAST) begin
        xCnt <= '0;
        if (yCnt == Y_LAST) begin
          yCnt <= '0;
        end else begin
          yCnt <= yCnt + Y_W'(1);
        end
      end else begin
        xCnt <= xCnt + X_W'(1);
      end
    end
  end

  assign oFF_almost_full = almostFull;
  assign oFF_full        = full;
  assign oFF_empty       = empty;
  assign oUsedw          = usedw;
  assign oOverflow       = overflow;
  assign oPixel          = pixel;
  assign oPixel_valid    = pixValid;
  assign oSOF            = pixValid && (xCnt == '0) && (yCnt == '0);
  assign oEOL            = pixValid && (xCnt == X_LAST);

endmodule

// File: tb/tb_read_fifo_pixel_unpacker.sv
// ---------------------------------------------------------------------------
// tb_read_fifo_pixel_unpacker
//   Scoreboard bench. Accepted words go into expQ as they are driven; the
//   monitor pops and compares whenever a pixel is handed over. Framing is
//   derived from the running pixel index; occupancy while the consumer is
//   stalled is derived from the number of words held (one sits in oPixel).
// ---------------------------------------------------------------------------
module tb_read_fifo_pixel_unpacker;

  localparam int DEPTH     = 64;
  localparam int ADDR_W    = 6;
  localparam int AF_MARGIN = 4;
  localparam int H         = 4;
  localparam int V         = 2;

  logic              iClk           = 1'b0;
  logic              iReset_n       = 1'b0;
  logic              iClear         = 1'b0;
  logic [31:0]       iRd_data       = '0;
  logic              iRd_Data_valid = 1'b0;
  logic              iPixel_ready   = 1'b0;
  logic              oFF_almost_full;
  logic              oFF_full;
  logic              oFF_empty;
  logic [ADDR_W:0]   oUsedw;
  logic              oOverflow;
  logic [23:0]       oPixel;
  logic              oPixel_valid;
  logic              oSOF;
  logic              oEOL;

  int          total    = 0;
  int          bad      = 0;
  logic [23:0] expQ[$];
  int          popIdx   = 0;
  bit          modelOvf = 1'b0;

  read_fifo_pixel_unpacker #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .AF_MARGIN (AF_MARGIN),
    .H_ACTIVE  (H),
    .V_ACTIVE  (V)
  ) dut (
    .iClk            (iClk),
    .iReset_n        (iReset_n),
    .iClear          (iClear),
    .iRd_data        (iRd_data),
    .iRd_Data_valid  (iRd_Data_valid),
    .oFF_almost_full (oFF_almost_full),
    .oFF_full        (oFF_full),
    .oFF_empty       (oFF_empty),
    .oUsedw          (oUsedw),
    .oOverflow       (oOverflow),
    .oPixel          (oPixel),
    .oPixel_valid    (oPixel_valid),
    .iPixel_ready    (iPixel_ready),
    .oSOF            (oSOF),
    .oEOL            (oEOL)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: every handed-over pixel must be the oldest accepted word.
  always @(negedge iClk) begin : monitor
    logic [23:0] expPix;
    if (iReset_n && oPixel_valid && iPixel_ready) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pixel actual=%0h required=no_pixel", oPixel);
      end else begin
        expPix = expQ.pop_front();
        check("pixel", oPixel, expPix);
        check("sof", oSOF, (popIdx % (H * V)) == 0);
        check("eol", oEOL, (popIdx % H) == (H - 1));
        popIdx++;
      end
    end
  end

  function automatic logic [31:0] rnd_word();
    return $urandom;
  endfunction

  // Called at posedge+1; returns at the next posedge+1 with valid dropped.
  task automatic write_word(input logic [31:0] w);
    iRd_data       = w;
    iRd_Data_valid = 1'b1;
    if (expQ.size() < DEPTH + 1) expQ.push_back(w[23:0]);
    else modelOvf = 1'b1;
    @(posedge iClk);
    #1;
    iRd_Data_valid = 1'b0;
  endtask

  // Valid only with the consumer stalled and the output register settled.
  task automatic check_settled(input string tag);
    int u;
    u = (expQ.size() > 0) ? expQ.size() - 1 : 0;
    check({tag, "_usedw"}, oUsedw, u);
    check({tag, "_af"}, oFF_almost_full, u >= DEPTH - AF_MARGIN);
    check({tag, "_full"}, oFF_full, u == DEPTH);
    check({tag, "_empty"}, oFF_empty, u == 0);
    check({tag, "_ovf"}, oOverflow, modelOvf);
    check({tag, "_valid"}, oPixel_valid, expQ.size() > 0);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    iPixel_ready = 1'b1;
    while ((expQ.size() != 0 || oPixel_valid) && n < 300) begin
      @(negedge iClk);
      n++;
    end
    check({tag, "_drained"}, expQ.size(), 0);
    @(posedge iClk);
    #1;
  endtask

  task automatic flush_model();
    expQ.delete();
    popIdx   = 0;
    modelOvf = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int gaps;

    // Reset values.
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    check("rst_valid", oPixel_valid, 0);
    check("rst_empty", oFF_empty, 1);
    check("rst_full", oFF_full, 0);
    check("rst_af", oFF_almost_full, 0);
    check("rst_usedw", oUsedw, 0);
    check("rst_ovf", oOverflow, 0);
    check("rst_sof", oSOF, 0);
    check("rst_eol", oEOL, 0);
    check("rst_pixel", oPixel, 0);
    iReset_n = 1'b1;

    // Single word, latency of two edges.
    @(posedge iClk);
    #1;
    iPixel_ready = 1'b1;
    write_word(32'h00AABBCC);
    @(negedge iClk);
    check("lat_n0_valid", oPixel_valid, 0);
    @(negedge iClk);
    check("lat_n1_valid", oPixel_valid, 0);
    @(negedge iClk);
    check("lat_n2_valid", oPixel_valid, 1);
    check("lat_n2_pixel", oPixel, 24'hAABBCC);
    check("lat_n2_sof", oSOF, 1);
    @(negedge iClk);
    check("lat_after_valid", oPixel_valid, 0);
    check("lat_after_empty", oFF_empty, 1);

    // Fill with consumer stalled, past full, to overflow.
    @(posedge iClk);
    #1;
    iPixel_ready = 1'b0;
    for (int k = 0; k < 66; k++) begin
      write_word(rnd_word());
      @(negedge iClk);
      if (expQ.size() >= 2) check_settled("fill");
      @(posedge iClk);
      #1;
    end

    // Drain everything at one pixel per cycle.
    iPixel_ready = 1'b1;
    gaps = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      @(negedge iClk);
      if (!oPixel_valid) gaps++;
    end
    check("drain_gaps", gaps, 0);
    @(negedge iClk);
    check_settled("drained");

    // Simultaneous write and pop with 10 words in RAM.
    @(posedge iClk);
    #1;
    iPixel_ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      write_word(rnd_word());
      @(posedge iClk);
      #1;
    end
    @(negedge iClk);
    check_settled("pre_stream");
    @(posedge iClk);
    #1;
    for (int i = 0; i < 20; i++) begin
      iPixel_ready   = 1'b1;
      iRd_data       = rnd_word();
      iRd_Data_valid = 1'b1;
      expQ.push_back(iRd_data[23:0]);
      @(negedge iClk);
      check("stream_usedw", oUsedw, 10);
      check("stream_valid", oPixel_valid, 1);
      @(posedge iClk);
      #1;
    end
    iRd_Data_valid = 1'b0;
    wait_drain("stream");

    // Random traffic; held words kept below capacity so nothing drops.
    for (int i = 0; i < 400; i++) begin
      iPixel_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && expQ.size() < 60) begin
        iRd_data       = rnd_word();
        iRd_Data_valid = 1'b1;
        expQ.push_back(iRd_data[23:0]);
      end else begin
        iRd_Data_valid = 1'b0;
      end
      @(posedge iClk);
      #1;
    end
    iRd_Data_valid = 1'b0;
    wait_drain("rand");

    // Clear at 30 words in RAM, with a write in the same cycle.
    iPixel_ready = 1'b0;
    for (int k = 0; k < 31; k++) begin
      write_word(rnd_word());
    end
    @(negedge iClk);
    check_settled("pre_clear");
    @(posedge iClk);
    #1;
    iClear         = 1'b1;
    iRd_data       = rnd_word();
    iRd_Data_valid = 1'b1;
    @(posedge iClk);
    #1;
    iClear         = 1'b0;
    iRd_Data_valid = 1'b0;
    flush_model();
    @(negedge iClk);
    check_settled("post_clear");
    @(posedge iClk);
    #1;
    for (int k = 0; k < 5; k++) begin
      write_word(rnd_word());
    end
    wait_drain("after_clear");

    // Asynchronous reset in the middle of a burst.
    iPixel_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      write_word(rnd_word());
    end
    iRd_data       = rnd_word();
    iRd_Data_valid = 1'b1;
    #2;
    iReset_n = 1'b0;
    #1;
    check("arst_valid", oPixel_valid, 0);
    check("arst_usedw", oUsedw, 0);
    check("arst_empty", oFF_empty, 1);
    check("arst_sof", oSOF, 0);
    iRd_Data_valid = 1'b0;
    iPixel_ready   = 1'b0;
    flush_model();
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iReset_n = 1'b1;
    @(posedge iClk);
    #1;
    check_settled("post_reset");
    for (int k = 0; k < 5; k++) begin
      write_word(rnd_word());
    end
    wait_drain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
